nes_oam_dma: RTL and testbench
==============================

# nes_oam_dma

Sprite DMA sequencer and bus owner for the nes6502 core. It sits between the CPU pins and the system memory bus. It forwards CPU cycles unchanged until the CPU writes a page number to the DMA register. It then stalls the CPU through a clock enable and copies 256 bytes from that page to the PPU OAM data port, one read cycle and one write cycle per byte.

## Interface
- DMA_REG, 16'h4014: CPU write address that triggers a transfer.
- OAM_PORT, 16'h2004: destination address for every DMA write.
- clock  in  1  system clock; same clock as the CPU (cpu_ce gates the CPU).
- reset  in  1  synchronous, active-high.
- cpu_address  in  16  CPU address.
- cpu_out  in  8  CPU write data.
- cpu_rd  in  1  CPU read strobe.
- cpu_we  in  1  CPU write strobe.
- cpu_ce  out  1  CPU clock enable; 0 while DMA owns the bus.
- address  out  16  memory bus address.
- out  out  8  memory bus write data.
- din  in  8  memory read data; valid the cycle after rd is asserted (synchronous RAM). Also routed to the CPU by the top level.
- rd  out  1  memory read strobe.
- we  out  1  memory write strobe.
- busy  out  1  1 in any state other than IDLE.

## Operation
- Registers:
  - state: IDLE, HALT, ALIGN, READ, WRITE.
  - page[7:0], idx[7:0].
  - odd: free-running parity bit; reset value 0; toggles every clock, including during reset release.
- IDLE:
  - address/out/rd/we are combinational copies of cpu_address/cpu_out/cpu_rd/cpu_we.
  - cpu_ce=1.
- Trigger: in IDLE, cpu_we=1 and cpu_address==DMA_REG:
  - The write still passes to the bus that cycle.
  - page <= cpu_out, idx <= 0, next state HALT.
- CPU reads of DMA_REG never trigger.
- HALT (1 cycle):
  - cpu_ce=0, rd=0, we=0, address=cpu_address, out=cpu_out.
  - Next state is READ if odd==1, else ALIGN.
- ALIGN (1 cycle): outputs as in HALT; next state READ. This guarantees every READ cycle has odd==0.
- READ:
  - cpu_ce=0, address={page,idx}, rd=1, we=0.
  - Next state WRITE.
- WRITE:
  - cpu_ce=0, address=OAM_PORT, out=din, we=1, rd=0.
  - idx <= idx+1, wrapping 8-bit.
  - If idx==8'hFF, next state IDLE; otherwise READ.
- Triggers while busy are impossible, because the CPU is stalled. Any cpu_we during non-IDLE states is ignored.
- Reset in any state:
  - state=IDLE, idx=0, page=0, odd=0.
  - The transfer is abandoned with no further bus writes.
- Reset values: cpu_ce=1, busy=0; bus outputs mirror the CPU inputs.

## Timing
- Cycle T is the trigger write.
- cpu_ce=0 from T+1 through the last WRITE.
- Total stall is 1 + 512 = 513 cycles when odd==1 in HALT, or 514 cycles with ALIGN.
- First READ is at T+2 (no ALIGN) or T+3 (with ALIGN). The last WRITE is at T+513 or T+514.
- The cycle after the last WRITE is IDLE with cpu_ce=1. The CPU resumes at the instruction after the trigger write.
- Byte k (k=0..255):
  - The READ of {page,k} occurs at cycle R+2k.
  - The WRITE of that data occurs at R+2k+1.
  - Source order is strictly ascending 00..FF.
- din is sampled combinationally in WRITE. No extra pipeline register.
- busy rises at T+1 and falls in the same cycle that cpu_ce returns to 1.

## Test plan
- Basic copy: preload RAM $0200..$02FF with value = low address byte, trigger write of 8'h02 to $4014.
  - Expect 256 writes to $2004 with data 00..FF in order, and reads from $0200..$02FF ascending.
  - Expect cpu_ce low for 513 or 514 cycles.
- Parity: trigger with odd==0 and, separately, odd==1 in HALT.
  - Expect a 514-cycle and a 513-cycle stall respectively.
  - Every READ has odd==0.
- Pass-through: in IDLE, CPU read $4014, write $4015, write $2004.
  - Bus mirrors CPU exactly, with no trigger and busy=0.
- Page wrap: trigger with page 8'hFF.
  - Reads cover $FF00..$FFFF; idx wraps to 0 and the state returns to IDLE.
- Reset mid-transfer: assert reset after the 100th WRITE.
  - Next cycle: cpu_ce=1, busy=0, no further $2004 writes.
  - A new trigger then starts again from idx 0.
- Ignored trigger: drive cpu_we=1 with cpu_address=$4014 and a different page during the transfer.
  - page is unchanged and the transfer completes normally.

Source files
------------

// File: rtl/nes_oam_dma.sv
// rtl/nes_oam_dma.sv - sprite DMA sequencer: forwards CPU bus cycles, copies one page to OAM on a $4014 write
module nes_oam_dma (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_rd,
  input  logic        cpu_we,
  output logic        cpu_ce,
  output logic [15:0] address,
  output logic [7:0]  out,
  input  logic [7:0]  din,
  output logic        rd,
  output logic        we,
  output logic        busy
);

  localparam logic [15:0] DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_PORT = 16'h2004;

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic        odd_q, odd_d;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    odd_d   = ~odd_q;
    cpu_ce  = 1'b0;
    busy    = 1'b1;
    address = cpu_address;
    out     = cpu_out;
    rd      = 1'b0;
    we      = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_ce = 1'b1;
        busy   = 1'b0;
        rd     = cpu_rd;
        we     = cpu_we;
        if (cpu_we && cpu_address == DMA_REG) begin
          page_d  = cpu_out;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      // Burn one extra cycle when needed so every READ lands on an even cycle.
      HALT:  state_d = odd_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        address = {page_q, idx_q};
        rd      = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        address = OAM_PORT;
        out     = din;
        we      = 1'b1;
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == 8'hFF) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      odd_q   <= odd_d;
    end
  end

endmodule

// File: tb/tb_nes_oam_dma.sv
// tb/tb_nes_oam_dma.sv - directed bench for nes_oam_dma with a synchronous RAM model
module tb_nes_oam_dma;

  localparam logic [15:0] DMA_REG = 16'h4014;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_address = 16'h0000;
  logic [7:0]  cpu_out = 8'h00;
  logic        cpu_rd = 1'b0;
  logic        cpu_we = 1'b0;
  logic        cpu_ce;
  logic [15:0] address;
  logic [7:0]  out;
  logic [7:0]  din = 8'h00;
  logic        rd;
  logic        we;
  logic        busy;

  logic [7:0]  mem [0:65535];
  logic        tb_odd = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  nes_oam_dma dut (
    .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
    .cpu_rd(cpu_rd), .cpu_we(cpu_we), .cpu_ce(cpu_ce), .address(address),
    .out(out), .din(din), .rd(rd), .we(we), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rd) din <= mem[address];
    tb_odd <= reset ? 1'b0 : ~tb_odd;
  end

  function automatic logic [7:0] exp_data(input logic [7:0] p, input logic [7:0] k);
    return (p == 8'h02) ? k : (k ^ p);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic pass_cycle(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
    @(negedge clock);
    cpu_address = a; cpu_out = d; cpu_rd = r; cpu_we = w;
    #1;
    check("pass_mirror", 32'({cpu_ce, busy, rd, we, address, out}),
          32'({1'b1, 1'b0, r, w, a, d}));
    @(negedge clock);
    cpu_rd = 1'b0; cpu_we = 1'b0;
    #1;
    check("pass_nobusy", 32'({busy, cpu_ce}), 32'({1'b0, 1'b1}));
  endtask

  task automatic run_dma(input logic [7:0] pg, input logic want_odd, input bit poke, input int stop_wr);
    int   stall = 0;
    int   first_rd = -1;
    int   nrd = 0;
    int   nwr = 0;
    int   bad = 0;
    int   stray = 0;
    bit   aborted = 1'b0;
    logic exp_align;
    @(negedge clock);
    while (tb_odd != want_odd) @(negedge clock);
    exp_align = tb_odd;
    cpu_address = DMA_REG; cpu_out = pg; cpu_we = 1'b1; cpu_rd = 1'b0;
    #1;
    check("trig_pass", 32'({busy, we, address, out}), 32'({1'b0, 1'b1, DMA_REG, pg}));
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clock);
      if (poke && nwr < 256) begin
        cpu_we = 1'b1; cpu_address = DMA_REG; cpu_out = ~pg;
      end else begin
        cpu_we = 1'b0; cpu_address = 16'h0000; cpu_out = 8'h00;
      end
      #1;
      if (busy == cpu_ce) bad++;
      if (cpu_ce) break;
      stall++;
      if (rd) begin
        if (first_rd < 0) first_rd = cyc;
        if (we || address != {pg, 8'(nrd)} || tb_odd || cyc != first_rd + 2 * nrd) bad++;
        nrd++;
      end else if (we) begin
        if (address != 16'h2004 || out != exp_data(pg, 8'(nwr)) || cyc != first_rd + 2 * nwr + 1) bad++;
        nwr++;
        if (nwr == stop_wr) begin
          aborted = 1'b1;
          break;
        end
      end else if (first_rd >= 0) begin
        bad++;
      end
    end
    cpu_we = 1'b0;
    if (aborted) begin
      reset = 1'b1;
      @(negedge clock);
      #1;
      check("rst_ce_busy", 32'({cpu_ce, busy}), 32'({1'b1, 1'b0}));
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock);
        #1;
        if (we || busy || !cpu_ce) stray++;
      end
      check("rst_quiet", 32'(stray), 32'd0);
      check("rst_bad", 32'(bad), 32'd0);
    end else begin
      check("stall_len", 32'(stall), exp_align ? 32'd514 : 32'd513);
      check("first_read", 32'(first_rd), exp_align ? 32'd3 : 32'd2);
      check("read_count", 32'(nrd), 32'd256);
      check("write_count", 32'(nwr), 32'd256);
      check("seq_errors", 32'(bad), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] a;
      a = 16'(i);
      mem[i] = exp_data(a[15:8], a[7:0]);
    end
    cpu_address = 16'hBEEF; cpu_out = 8'h5A; cpu_rd = 1'b1; cpu_we = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("reset_ce_busy", 32'({cpu_ce, busy}), 32'({1'b1, 1'b0}));
    check("reset_mirror", 32'({rd, we, address, out}), 32'({1'b1, 1'b0, 16'hBEEF, 8'h5A}));
    @(negedge clock);
    reset = 1'b0; cpu_rd = 1'b0;

    pass_cycle(DMA_REG, 8'h33, 1'b1, 1'b0);
    pass_cycle(16'h4015, 8'h0F, 1'b0, 1'b1);
    pass_cycle(16'h2004, 8'hA5, 1'b0, 1'b1);

    run_dma(8'h02, 1'b0, 1'b0, 0);
    run_dma(8'h02, 1'b1, 1'b0, 0);
    run_dma(8'hFF, 1'b0, 1'b1, 0);
    run_dma(8'h10, 1'b1, 1'b0, 100);
    run_dma(8'h03, 1'b1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
